penalty_round_scorer: RTL
=========================

Name: penalty_round_scorer

Overview:
- Producer of the round-progress fields `is_scored`, `round_counter` and `score` on `control_if`. `game_state_sel` consumes these fields to leave KEEPER/SHOOTER for WINNER/LOOSER.
- Takes one-cycle shot-outcome events from the shot/keeper logic and counts completed rounds and rounds won by the player.
- Holds each result for a display interval, then emits a one-cycle `is_scored` pulse.
- Sits between the shot-resolution logic and `game_state_sel`, in the control pipeline.

Parameters:
- ROUNDS, 5: rounds per game; `round_counter` runs 0..ROUNDS-1.
- HOLD_CYCLES, 65_000_000: cycles the round result is held before `is_scored` is pulsed (1 s at 65 MHz). Must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- game_state  in  3  current `g_state` from `game_pkg` (START, KEEPER, SHOOTER, WINNER, LOOSER), registered output of `game_state_sel`
- shot_valid  in  1  one-cycle pulse: a shot has been resolved
- shot_goal  in  1  qualifies `shot_valid`: 1 = ball entered goal, 0 = saved/missed
- is_scored  out  1  one-cycle pulse: current round is finished and counted
- round_counter  out  4  index of the current/just-finished round
- score  out  3  rounds won by the player in this game
- last_win  out  1  1 = player won the most recent round (valid from HOLD onward)
- busy  out  1  1 while in HOLD or REPORT; shot logic must not issue shots

Behaviour:
- Reset values: `is_scored`=0, `round_counter`=0, `score`=0, `last_win`=0, `busy`=0, FSM=IDLE, hold counter=0. All outputs are registered.
- Round-win rule:
  - In KEEPER, the player wins when `shot_goal`=0.
  - In SHOOTER, the player wins when `shot_goal`=1.
  - `win` is evaluated in the cycle `shot_valid` is sampled.
- FSM states:
  - IDLE
    - Entered from reset, or whenever `game_state`==START.
    - In START, `round_counter` and `score` are cleared every cycle.
    - Next state is WAIT_SHOT when `game_state` is KEEPER or SHOOTER.
  - WAIT_SHOT
    - On `shot_valid`=1: `last_win`<=`win`; `score`<=`score`+`win`, saturating at 7; hold counter<=0; next state HOLD.
    - `shot_valid` outside WAIT_SHOT is ignored.
  - HOLD
    - `busy`=1; hold counter increments.
    - When counter==HOLD_CYCLES-1, next state is REPORT.
  - REPORT
    - Lasts exactly one cycle: `is_scored`=1, `busy`=1.
    - If `round_counter`==ROUNDS-1: `round_counter` is held and next state is DONE.
    - Otherwise: `round_counter` increments on the clock edge ending REPORT; next state WAIT_SHOT.
  - DONE
    - `round_counter` and `score` are frozen so `game_state_sel` samples final values.
    - `shot_valid` is ignored.
    - Leaves to IDLE only when `game_state`==START.
- Latency:
  - `shot_valid` sampled in cycle t → `score`/`last_win` updated at t+1.
  - `is_scored` is high in cycle t+1+HOLD_CYCLES.
  - `round_counter` update, if any, is visible at t+2+HOLD_CYCLES.
- `score` at the `is_scored` pulse already includes the current round. `round_counter` at the pulse equals the index of the round just finished; the final pulse occurs with `round_counter`=ROUNDS-1 (4).
- `game_state` changing to START from any FSM state forces IDLE next cycle:
  - counters cleared;
  - any pending hold aborted;
  - no `is_scored` pulse.
- `game_state` in WINNER/LOOSER while not in DONE: FSM goes to DONE, values frozen.
- Simultaneous `shot_valid` and a `game_state`→START transition: START has priority and the shot is discarded.
- Widths: `score` 3-bit, saturating. `round_counter` 4-bit. Hold counter width is $clog2(HOLD_CYCLES+1).
- Mid-operation `rst` overrides everything and returns all outputs to their reset values on the next edge.

Test Plan:
- Reset, then `game_state`=KEEPER, one `shot_valid` with `shot_goal`=0 (HOLD_CYCLES=4):
  - `score`=1 and `last_win`=1 one cycle later;
  - `is_scored` high for exactly 1 cycle, 5 cycles after the shot;
  - `round_counter` 0→1 on the following cycle.
- KEEPER, five shots with `shot_goal` pattern 0,1,0,0,1:
  - fifth `is_scored` pulse seen with `round_counter`=4, `score`=3;
  - values stay frozen in DONE until `game_state`=START, then both read 0.
- SHOOTER, five shots with `shot_goal`=1,1,0,0,0: final pulse with `round_counter`=4, `score`=2.
- `shot_valid` pulses during HOLD and during DONE: `score`/`round_counter` unchanged, no extra `is_scored`.
- `game_state` forced to START in the middle of HOLD: no `is_scored`; `round_counter`=0, `score`=0, `busy`=0 next cycle.
- `rst` asserted in REPORT cycle (and in WAIT_SHOT with `score`=2): all outputs 0 on the next edge; a fresh KEEPER game afterwards counts from round 0.

Source files
------------

// File: rtl/penalty_round_scorer.sv
// Round/score bookkeeping for the penalty game: counts resolved shots, tracks
// player wins, holds each result for a display interval and then pulses is_scored.
module penalty_round_scorer #(
  parameter int ROUNDS      = 5,
  parameter int HOLD_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] game_state,
  input  logic       shot_valid,
  input  logic       shot_goal,
  output logic       is_scored,
  output logic [3:0] round_counter,
  output logic [2:0] score,
  output logic       last_win,
  output logic       busy
);

  localparam logic [2:0] GS_START   = 3'd0;
  localparam logic [2:0] GS_KEEPER  = 3'd1;
  localparam logic [2:0] GS_SHOOTER = 3'd2;
  localparam logic [2:0] GS_WINNER  = 3'd3;
  localparam logic [2:0] GS_LOOSER  = 3'd4;

  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]      ROUND_LAST = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {IDLE, WAIT_SHOT, HOLD, REPORT, DONE} state_t;

  state_t          state, next_state;
  logic [HC_W-1:0] hold_cnt;
  logic            win;

  function automatic logic [2:0] sat_add(input logic [2:0] a, input logic b);
    return (a == 3'd7) ? a : a + {2'b00, b};
  endfunction

  // The player defends in KEEPER and attacks in SHOOTER.
  always_comb begin
    win = 1'b0;
    if (game_state == GS_KEEPER)       win = ~shot_goal;
    else if (game_state == GS_SHOOTER) win = shot_goal;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (game_state == GS_KEEPER || game_state == GS_SHOOTER) next_state = WAIT_SHOT;
      WAIT_SHOT: if (shot_valid) next_state = HOLD;
      HOLD:      if (hold_cnt == HOLD_LAST) next_state = REPORT;
      REPORT:    next_state = (round_counter == ROUND_LAST) ? DONE : WAIT_SHOT;
      DONE:      next_state = DONE;
      default:   next_state = IDLE;
    endcase
    // START aborts everything; a decided game freezes the results.
    if (game_state == GS_START)
      next_state = IDLE;
    else if ((game_state == GS_WINNER || game_state == GS_LOOSER) && state != DONE)
      next_state = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      is_scored     <= 1'b0;
      round_counter <= '0;
      score         <= '0;
      last_win      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state     <= next_state;
      is_scored <= (next_state == REPORT);
      busy      <= (next_state == HOLD) || (next_state == REPORT);
      if (game_state == GS_START) begin
        round_counter <= '0;
        score         <= '0;
        hold_cnt      <= '0;
      end else begin
        case (state)
          WAIT_SHOT: if (next_state == HOLD) begin
            last_win <= win;
            score    <= sat_add(score, win);
            hold_cnt <= '0;
          end
          HOLD:      hold_cnt <= hold_cnt + 1'b1;
          REPORT:    if (next_state == WAIT_SHOT) round_counter <= round_counter + 4'd1;
          default:   ;
        endcase
      end
    end
  end

endmodule
